pdp8l_iot_seq: RTL

PDP8L_IOT_SEQ -- requirements
Module: pdp8l_iot_seq

---
 rtl/pdp8l_iot_pkg.sv | 20 ++
 rtl/pdp8l_iot_seq.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pdp8l_iot_pkg.sv
// pdp8l_iot_pkg: register map, RESULT/CMD bit positions, ID constant and FSM encoding
package pdp8l_iot_pkg;
    localparam logic [2:0]  REG_ID      = 3'd0;
    localparam logic [2:0]  REG_CMD     = 3'd1;
    localparam logic [2:0]  REG_RESULT  = 3'd2;
    localparam logic [2:0]  REG_TIMING  = 3'd3;
    localparam logic [31:0] ID_VALUE    = 32'h494F2001;
    localparam logic [31:0] BAD_VALUE   = 32'hDEADBEEF;
    localparam logic [15:0] TIMING_RST  = 16'h0401;
    localparam int          CMD_GO      = 24;
    localparam int          CMD_WAITINT = 25;
    localparam int          RES_SKIP    = 12;
    localparam int          RES_ACCLR   = 13;
    localparam int          RES_INT     = 14;
    localparam int          RES_OVERRUN = 15;
    localparam int          RES_BADOP   = 16;
    localparam int          RES_BUSY    = 30;
    localparam int          RES_DONE    = 31;
    typedef enum logic [2:0] {S_IDLE, S_WAITINT, S_START, S_HOLD, S_STOP, S_GAP} state_t;
endpackage

// File: rtl/pdp8l_iot_seq.sv
// pdp8l_iot_seq: ARM-driven PDP-8/L IOT bus sequencer (optional WAITINT state: PDP8L_IOT_WAITINT_EN)
module pdp8l_iot_seq
    import pdp8l_iot_pkg::*;
(
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic        CSTEP,
    input  logic        armwrite,
    input  logic [2:0]  armwaddr,
    input  logic [2:0]  armraddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,
    output logic        iopstart,
    output logic        iopstop,
    output logic [11:0] ioopcode,
    output logic [11:0] cputodev,
    input  logic [11:0] devtocpu,
    input  logic        AC_CLEAR,
    input  logic        IO_SKIP,
    input  logic        INT_RQST,
    output logic        busy
);
`ifdef PDP8L_IOT_WAITINT_EN
    localparam logic [31:0] CMD_MASK = 32'h0100_0000;
`else
    localparam logic [31:0] CMD_MASK = 32'h0300_0000;
`endif
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [11:0] op_q, op_d, ac_q, ac_d, res_q, res_d;
    logic [31:0] cmd_q, cmd_d;
    logic [15:0] timing_q, timing_d;
    logic        skip_q, skip_d, acclr_q, acclr_d, ovr_q, ovr_d, badop_q, badop_d, done_q, done_d;
    logic        cmd_wr, go, wi;
    logic [7:0]  hold_n, gap_n;

    // Register writes, FSM next state and the shared HOLD/GAP down-counter
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        ac_d     = ac_q;
        res_d    = res_q;
        cmd_d    = cmd_q;
        timing_d = timing_q;
        skip_d   = skip_q;
        acclr_d  = acclr_q;
        ovr_d    = ovr_q;
        badop_d  = badop_q;
        done_d   = done_q;
        cmd_wr   = armwrite && armwaddr == REG_CMD;
        go       = cmd_wr && armwdata[CMD_GO];
        wi       = armwdata[CMD_WAITINT] && !CMD_MASK[CMD_WAITINT];
        hold_n   = timing_q[7:0] == 8'd0 ? 8'd1 : timing_q[7:0];
        gap_n    = timing_q[15:8];
        if (cmd_wr) cmd_d = armwdata & ~CMD_MASK;
        if (armwrite && armwaddr == REG_TIMING) timing_d = armwdata[15:0];
        if (armwrite && armwaddr == REG_RESULT) begin
            done_d = 1'b0;
            ovr_d  = 1'b0;
        end
        if (go && state_q != S_IDLE) ovr_d = 1'b1;
        if (CSTEP) begin
            case (state_q)
                S_IDLE: if (go) begin
                    done_d  = armwdata[11:9] != 3'o6;
                    badop_d = armwdata[11:9] != 3'o6;
                    skip_d  = 1'b0;
                    acclr_d = 1'b0;
                    op_d    = armwdata[11:0];
                    ac_d    = armwdata[23:12];
                    if (armwdata[11:9] == 3'o6) state_d = wi ? S_WAITINT : S_START;
                end
`ifdef PDP8L_IOT_WAITINT_EN
                S_WAITINT: state_d = INT_RQST ? S_START :
                                     (cmd_wr && !armwdata[CMD_GO] && !armwdata[CMD_WAITINT]) ? S_IDLE : S_WAITINT;
`else
                S_WAITINT: state_d = S_START;
`endif
                S_START: begin
                    state_d = S_HOLD;
                    cnt_d   = hold_n;
                end
                S_HOLD: if (cnt_q == 8'd1) begin
                    res_d   = (AC_CLEAR ? 12'd0 : ac_q) | devtocpu;
                    skip_d  = IO_SKIP;
                    acclr_d = AC_CLEAR;
                    state_d = S_STOP;
                end else cnt_d = cnt_q - 8'd1;
                S_STOP: begin
                    state_d = gap_n == 8'd0 ? S_IDLE : S_GAP;
                    done_d  = gap_n == 8'd0 ? 1'b1 : done_d;
                    cnt_d   = gap_n;
                end
                S_GAP: if (cnt_q == 8'd1) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else cnt_d = cnt_q - 8'd1;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State register with synchronous active-low reset; reset aborts any sequence
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            op_q     <= 12'd0;
            ac_q     <= 12'd0;
            res_q    <= 12'd0;
            cmd_q    <= 32'd0;
            timing_q <= TIMING_RST;
            skip_q   <= 1'b0;
            acclr_q  <= 1'b0;
            ovr_q    <= 1'b0;
            badop_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            ac_q     <= ac_d;
            res_q    <= res_d;
            cmd_q    <= cmd_d;
            timing_q <= timing_d;
            skip_q   <= skip_d;
            acclr_q  <= acclr_d;
            ovr_q    <= ovr_d;
            badop_q  <= badop_d;
            done_q   <= done_d;
        end
    end

    // Bus strobes decode straight from state; read mux is combinational on armraddr
    always_comb begin
        busy     = state_q != S_IDLE;
        iopstart = state_q == S_START;
        iopstop  = state_q == S_STOP;
        ioopcode = busy ? op_q : 12'd0;
        cputodev = busy ? ac_q : 12'd0;
        armrdata = armraddr == REG_ID     ? ID_VALUE :
                   armraddr == REG_CMD    ? cmd_q :
                   armraddr == REG_RESULT ? {done_q, busy, 13'd0, badop_q, ovr_q, INT_RQST, acclr_q, skip_q, res_q} :
                   armraddr == REG_TIMING ? {16'd0, timing_q} : BAD_VALUE;
    end
endmodule
